mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared unified memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Sequences each 8-word block fill: issues addresses, counts returning words, steers data-valid to the owning cache and signals completion.
- Sits between both cache controllers and the multi-cycle memory model; its busy outputs feed the pipeline stall logic.

Parameters:
- MEM_LAT, 4, cycles from mem_en (read) to the matching mem_data_valid; legal range 1..8.
- WORDS, 8, words per cache block; fixed, with word stride 2 bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icache_miss  in  1  I-cache fill request, held high until icache_fill_done
- icache_addr  in  16  I-cache missing address
- dcache_miss  in  1  D-cache fill request, held high until dcache_fill_done
- dcache_addr  in  16  D-cache missing address
- dmem_write  in  1  D-cache store request, held high until dmem_write_ack
- dmem_wr_addr  in  16  store address
- dmem_wr_data  in  16  store data
- mem_data_valid  in  1  memory read data valid
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write (valid only with mem_en)
- mem_addr  out  16  memory address
- mem_wr_data  out  16  memory write data
- icache_data_valid  out  1  mem_data_valid steered to the I-cache
- dcache_data_valid  out  1  mem_data_valid steered to the D-cache
- fill_word  out  3  word index of the current returning word
- icache_fill_done  out  1  1-cycle pulse: I-cache block complete; used as the tag write enable
- dcache_fill_done  out  1  1-cycle pulse: D-cache block complete; used as the tag write enable
- dmem_write_ack  out  1  1-cycle pulse: store performed
- icache_busy  out  1  high while I-cache request is pending or being serviced
- dcache_busy  out  1  high while D-cache miss or store is pending or being serviced

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- Reset, asynchronous: state IDLE; issue and receive counters 0; latched base 0; all outputs 0.
- IDLE priority, fixed: dmem_write > dcache_miss > icache_miss. The grant is registered, and the new state is entered on the next edge.
- On a fill grant, latch base = addr[15:4], 4'h0.
- FILL issue phase, lasting WORDS cycles:
  - Cycle k (0..7) after entry: mem_en=1, mem_wr=0, mem_addr = base + 2k.
  - After 8 issues, mem_en=0.
- FILL receive phase:
  - Each mem_data_valid increments the receive counter (0..8).
  - fill_word = receive counter[2:0] in the same cycle, so word 0 arrives with fill_word 0.
  - Only the owning {i,d}cache_data_valid mirrors mem_data_valid.
- Completion: the cycle after the 8th valid, the owner's fill_done pulses for 1 cycle and state returns to IDLE. A new grant can be taken in that same cycle, so fill_done and the next state entry coincide.
- D_WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=dmem_wr_addr, mem_wr_data=dmem_wr_data; dmem_write_ack=1 in the same cycle; next state IDLE.
- mem_data_valid while IDLE or D_WRITE is ignored: no steering, no count.
- A requester deasserting mid-fill does not abort the fill; it runs to completion and still pulses done.
- Busy outputs are combinational:
  - icache_busy = icache_miss | (state==I_FILL).
  - dcache_busy = dcache_miss | dmem_write | (state==D_FILL) | (state==D_WRITE).
- A simultaneous miss and store from the D-cache: the store is served first, then the miss.
- mem_wr_data is 0 except in D_WRITE.
- Counters are 4-bit and do not wrap. The receive counter saturates at 8 until it is cleared on IDLE entry.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-fill-owner flop (reset: I-cache) arbitrates between dcache_miss and icache_miss, giving the fill to the requester that did not own the previous fill. Stores keep absolute priority.
- Undefined: fixed priority dmem_write > dcache_miss > icache_miss.

Test Plan:
- Reset: hold rst_n=0 mid-D_FILL (word 3 received) -> all outputs 0 immediately; after release, a re-requested fill restarts at base+0.
- I-miss 0x1236 alone, MEM_LAT=4 -> mem_addr 0x1230,0x1232,...,0x123E on 8 consecutive cycles; 8 icache_data_valid with fill_word 0..7; icache_fill_done pulses 1 cycle after the 8th valid; dcache_data_valid stays 0.
- icache_miss and dcache_miss rise in the same cycle (macro off) -> D fill completes first, then the I fill starts the same cycle dcache_fill_done pulses.
- dmem_write 0x00A0/0xBEEF plus dcache_miss together -> one write cycle with mem_wr=1, mem_addr 0x00A0, data 0xBEEF, ack=1; D_FILL begins the next cycle.
- Spurious mem_data_valid in IDLE -> no data_valid outputs, no done pulses, fill_word stays 0.
- ARB_ROUND_ROBIN_EN defined, both misses held continuously -> fill owners alternate I, D, I, D, starting with D.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: sequences I/D-cache 8-word block fills and D-cache write-through stores.
// Build option ARB_ROUND_ROBIN_EN alternates fill ownership between the two caches.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_miss,
  input  logic [15:0] icache_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_addr,
  input  logic        dmem_write,
  input  logic [15:0] dmem_wr_addr,
  input  logic [15:0] dmem_wr_data,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wr_data,
  output logic        icache_data_valid,
  output logic        dcache_data_valid,
  output logic [2:0]  fill_word,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        dmem_write_ack,
  output logic        icache_busy,
  output logic        dcache_busy
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] ALL_WORDS = CW'(WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t        state;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] recv_cnt;
  logic [AW-1:0] base;

  logic          in_fill;
  logic          fill_last;
  logic          free;
  logic          pend_w;
  logic          pend_d;
  logic          pend_i;
  logic          grant_d;
  logic          grant_i;
  logic [AW-1:0] fill_addr;

  assign in_fill   = (state == I_FILL) || (state == D_FILL);
  assign fill_last = in_fill && mem_data_valid && (recv_cnt == LAST_WORD);
  assign free      = (state == IDLE) || (state == D_WRITE) || fill_last;

  // A request whose done/ack is visible this cycle is stale; so is the owner of a completing fill.
  assign pend_w = dmem_write && !dmem_write_ack;
  assign pend_d = dcache_miss && !dcache_fill_done && (state != D_FILL);
  assign pend_i = icache_miss && !icache_fill_done && (state != I_FILL);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign grant_d = !pend_w && pend_d && (!pend_i || !last_d);
`else
  assign grant_d = !pend_w && pend_d;
`endif
  assign grant_i   = !pend_w && pend_i && !grant_d;
  assign fill_addr = grant_d ? dcache_addr : icache_addr;

  assign icache_data_valid = mem_data_valid && (state == I_FILL);
  assign dcache_data_valid = mem_data_valid && (state == D_FILL);
  assign fill_word         = recv_cnt[2:0];
  assign icache_busy       = icache_miss || (state == I_FILL);
  assign dcache_busy       = dcache_miss || dmem_write || (state == D_FILL) || (state == D_WRITE);

  // Sequencer: grant, issue addresses, count returning words, pulse completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      base             <= '0;
      mem_en           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_addr         <= '0;
      mem_wr_data      <= '0;
      icache_fill_done <= 1'b0;
      dcache_fill_done <= 1'b0;
      dmem_write_ack   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d           <= 1'b0;
`endif
    end else begin
      mem_en           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_addr         <= '0;
      mem_wr_data      <= '0;
      icache_fill_done <= 1'b0;
      dcache_fill_done <= 1'b0;
      dmem_write_ack   <= 1'b0;

      if (in_fill) begin
        if (issue_cnt < ALL_WORDS) begin
          mem_en    <= 1'b1;
          mem_addr  <= base + AW'({issue_cnt, 1'b0});
          issue_cnt <= issue_cnt + CW'(1);
        end
        if (mem_data_valid && (recv_cnt < ALL_WORDS)) begin
          recv_cnt <= recv_cnt + CW'(1);
        end
      end

      if (fill_last) begin
        icache_fill_done <= (state == I_FILL);
        dcache_fill_done <= (state == D_FILL);
        state            <= IDLE;
        issue_cnt        <= '0;
        recv_cnt         <= '0;
      end

      if (state == D_WRITE) begin
        state <= IDLE;
      end

      // Next owner is granted in the same edge the previous service ends.
      if (free) begin
        if (pend_w) begin
          state          <= D_WRITE;
          mem_en         <= 1'b1;
          mem_wr         <= 1'b1;
          mem_addr       <= dmem_wr_addr;
          mem_wr_data    <= dmem_wr_data;
          dmem_write_ack <= 1'b1;
        end else if (grant_d || grant_i) begin
          state     <= grant_d ? D_FILL : I_FILL;
          base      <= fill_addr & 16'hFFF0;
          mem_en    <= 1'b1;
          mem_addr  <= fill_addr & 16'hFFF0;
          issue_cnt <= CW'(1);
          recv_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d    <= grant_d;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: service-level reference model, latency memory model,
// directed scenarios followed by randomized requester traffic.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 4;
  localparam int unsigned WORDS   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_addr = '0;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_addr = '0;
  logic        dmem_write = 1'b0;
  logic [15:0] dmem_wr_addr = '0;
  logic [15:0] dmem_wr_data = '0;
  logic        mem_data_valid = 1'b0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wr_data;
  logic        icache_data_valid, dcache_data_valid;
  logic [2:0]  fill_word;
  logic        icache_fill_done, dcache_fill_done, dmem_write_ack;
  logic        icache_busy, dcache_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dmem_write(dmem_write), .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
    .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .icache_data_valid(icache_data_valid), .dcache_data_valid(dcache_data_valid),
    .fill_word(fill_word),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .dmem_write_ack(dmem_write_ack),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which service is active and how far it has progressed.
  typedef enum int {S_NONE, S_I, S_D, S_W} srv_t;
  srv_t        srv = S_NONE;
  int          k = 0;
  int          recv = 0;
  logic [15:0] base = '0;
  logic [15:0] wa = '0;
  logic [15:0] wd = '0;
  logic        done_i = 1'b0;
  logic        done_d = 1'b0;
  logic        last_was_d = 1'b0;

  int   cyc = 0;
  int   due_q[$];
  logic spur = 1'b0;
  logic rand_mode = 1'b0;
  logic hold = 1'b0;
  logic ret_i = 1'b0, ret_d = 1'b0, ret_w = 1'b0;

  int          n_iv, n_dv, n_idone, n_ddone, last_iv_cyc, i_done_cyc, d_done_cyc, wr_cyc;
  int          rd_start_cyc;
  logic [15:0] rd_start_addr, wr_addr_seen, wr_data_seen;
  logic        prev_rd;
  int          fw_q[$];
  int          order_q[$];
  logic [15:0] rd_q[$];
  int          budget;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_trackers();
    n_iv = 0; n_dv = 0; n_idone = 0; n_ddone = 0;
    last_iv_cyc = -1; i_done_cyc = -1; d_done_cyc = -1; wr_cyc = -1;
    rd_start_cyc = -1; rd_start_addr = '0; wr_addr_seen = '0; wr_data_seen = '0;
    prev_rd = 1'b0;
    fw_q.delete(); order_q.delete(); rd_q.delete();
  endtask

  task automatic reset_model();
    srv = S_NONE; k = 0; recv = 0; base = '0;
    done_i = 1'b0; done_d = 1'b0; last_was_d = 1'b0;
    due_q.delete();
    ret_i = 1'b0; ret_d = 1'b0; ret_w = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".mem_en"}, mem_en, 0);
    chk({tag, ".mem_wr"}, mem_wr, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wr_data"}, mem_wr_data, 0);
    chk({tag, ".icache_data_valid"}, icache_data_valid, 0);
    chk({tag, ".dcache_data_valid"}, dcache_data_valid, 0);
    chk({tag, ".fill_word"}, fill_word, 0);
    chk({tag, ".icache_fill_done"}, icache_fill_done, 0);
    chk({tag, ".dcache_fill_done"}, dcache_fill_done, 0);
    chk({tag, ".dmem_write_ack"}, dmem_write_ack, 0);
    chk({tag, ".icache_busy"}, icache_busy, 0);
    chk({tag, ".dcache_busy"}, dcache_busy, 0);
  endtask

  // Compare every output against the service model for the current cycle.
  task automatic monitor();
    logic        fill;
    logic        exp_en;
    logic [15:0] exp_addr;
    fill     = (srv == S_I) || (srv == S_D);
    exp_en   = (srv == S_W) || (fill && k < int'(WORDS));
    exp_addr = (srv == S_W) ? wa : base + 16'(2 * k);
    chk("mem_en", mem_en, exp_en);
    chk("mem_wr", mem_wr, srv == S_W);
    if (exp_en) chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wr_data", mem_wr_data, (srv == S_W) ? wd : 16'h0);
    chk("dmem_write_ack", dmem_write_ack, srv == S_W);
    chk("icache_data_valid", icache_data_valid, (srv == S_I) && mem_data_valid);
    chk("dcache_data_valid", dcache_data_valid, (srv == S_D) && mem_data_valid);
    chk("fill_word", fill_word, fill ? 3'(recv) : 3'd0);
    chk("icache_fill_done", icache_fill_done, done_i);
    chk("dcache_fill_done", dcache_fill_done, done_d);
    chk("icache_busy", icache_busy, icache_miss || (srv == S_I));
    chk("dcache_busy", dcache_busy, dcache_miss || dmem_write || (srv == S_D) || (srv == S_W));

    if (mem_en && !mem_wr) begin
      due_q.push_back(cyc + int'(MEM_LAT));
      rd_q.push_back(mem_addr);
      if (!prev_rd) begin rd_start_cyc = cyc; rd_start_addr = mem_addr; end
    end
    prev_rd = mem_en && !mem_wr;
    if (mem_en && mem_wr) begin wr_cyc = cyc; wr_addr_seen = mem_addr; wr_data_seen = mem_wr_data; end
    if (icache_data_valid) begin n_iv++; fw_q.push_back(int'(fill_word)); last_iv_cyc = cyc; end
    if (dcache_data_valid) n_dv++;
    if (icache_fill_done) begin n_idone++; order_q.push_back(0); i_done_cyc = cyc; end
    if (dcache_fill_done) begin n_ddone++; order_q.push_back(1); d_done_cyc = cyc; end
    ret_i = icache_fill_done;
    ret_d = dcache_fill_done;
    ret_w = dmem_write_ack;
  endtask

  task automatic start_fill(input srv_t who, input logic [15:0] addr);
    srv  = who;
    base = addr & 16'hFFF0;
    k    = 0;
    recv = 0;
    last_was_d = (who == S_D);
  endtask

  // Advance the model to the next cycle from this cycle's requests and memory response.
  task automatic model_update();
    logic fill, completing, pw, pd, pi, prefer_d, nd_i, nd_d;
    fill       = (srv == S_I) || (srv == S_D);
    completing = fill && mem_data_valid && (recv == int'(WORDS) - 1);
    pw = dmem_write && (srv != S_W);
    pd = dcache_miss && !done_d && (srv != S_D);
    pi = icache_miss && !done_i && (srv != S_I);
`ifdef ARB_ROUND_ROBIN_EN
    prefer_d = !last_was_d;
`else
    prefer_d = 1'b1;
`endif
    nd_i = completing && (srv == S_I);
    nd_d = completing && (srv == S_D);
    if (fill) begin
      k++;
      if (mem_data_valid) recv++;
    end
    if (srv == S_NONE || srv == S_W || completing) begin
      if (pw) begin
        srv = S_W; wa = dmem_wr_addr; wd = dmem_wr_data;
      end else if (pd && (!pi || prefer_d)) begin
        start_fill(S_D, dcache_addr);
      end else if (pi) begin
        start_fill(S_I, icache_addr);
      end else begin
        srv = S_NONE;
      end
    end
    done_i = nd_i;
    done_d = nd_d;
  endtask

  // One clock: check at negedge, then drive the next cycle's inputs just after posedge.
  task automatic cycle();
    logic drop_i, drop_d, drop_w;
    @(negedge clk);
    monitor();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    drop_i = ret_i && !hold;
    drop_d = ret_d && !hold;
    drop_w = ret_w;
    if (drop_i) icache_miss = 1'b0;
    if (drop_d) dcache_miss = 1'b0;
    if (drop_w) dmem_write = 1'b0;
    if (rand_mode) begin
      if (!icache_miss && !drop_i && $urandom_range(0, 4) == 0) begin
        icache_miss = 1'b1; icache_addr = 16'($urandom);
      end
      if (!dcache_miss && !drop_d && $urandom_range(0, 5) == 0) begin
        dcache_miss = 1'b1; dcache_addr = 16'($urandom);
      end
      if (!dmem_write && !drop_w && $urandom_range(0, 7) == 0) begin
        dmem_write = 1'b1; dmem_wr_addr = 16'($urandom); dmem_wr_data = 16'($urandom);
      end
      spur = (srv == S_NONE || srv == S_W) && ($urandom_range(0, 9) == 0);
    end
    mem_data_valid = spur;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      mem_data_valid = 1'b1;
    end
  endtask

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    cycle();
    while ((icache_miss || dcache_miss || dmem_write || srv != S_NONE) && n < 400) begin
      cycle();
      n++;
    end
    chk({tag, ".completed_in_budget"}, n < 400, 1);
  endtask

  initial begin
    clear_trackers();
    #1;
    check_all_zero("reset_init");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    cycle(); cycle();

    // I-miss alone: 8 consecutive issues, 8 steered words, done one cycle after the last.
    clear_trackers();
    icache_addr = 16'h1236; icache_miss = 1'b1;
    run_until_idle("imiss");
    chk("imiss.n_reads", rd_q.size(), 8);
    for (int j = 0; j < rd_q.size() && j < 8; j++) chk("imiss.addr", rd_q[j], 16'h1230 + 16'(2 * j));
    chk("imiss.n_ivalid", n_iv, 8);
    chk("imiss.n_dvalid", n_dv, 0);
    for (int j = 0; j < fw_q.size() && j < 8; j++) chk("imiss.fill_word", fw_q[j], j);
    chk("imiss.n_done", n_idone, 1);
    chk("imiss.done_cycle", i_done_cyc, last_iv_cyc + 1);

    // Simultaneous misses: D first, I starts the cycle dcache_fill_done pulses.
    clear_trackers();
    icache_addr = 16'h2004; dcache_addr = 16'h345A;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    run_until_idle("both");
    chk("both.n_fills", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("both.first_owner_d", order_q[0], 1);
      chk("both.second_owner_i", order_q[1], 0);
    end
    chk("both.i_start_addr", rd_start_addr, 16'h2000);
    chk("both.i_start_eq_d_done", rd_start_cyc, d_done_cyc);

    // Store plus D-miss: one write cycle, D fill issues on the very next cycle.
    clear_trackers();
    dmem_wr_addr = 16'h00A0; dmem_wr_data = 16'hBEEF; dmem_write = 1'b1;
    dcache_addr = 16'h0F08; dcache_miss = 1'b1;
    run_until_idle("wr_miss");
    chk("wr_miss.wr_addr", wr_addr_seen, 16'h00A0);
    chk("wr_miss.wr_data", wr_data_seen, 16'hBEEF);
    chk("wr_miss.fill_next_cycle", rd_start_cyc, wr_cyc + 1);
    chk("wr_miss.fill_base", rd_start_addr, 16'h0F00);
    chk("wr_miss.n_ddone", n_ddone, 1);

    // Spurious memory valids while idle are ignored.
    clear_trackers();
    spur = 1'b1; mem_data_valid = 1'b1;
    cycle(); cycle(); cycle();
    spur = 1'b0; mem_data_valid = 1'b0;
    cycle();
    chk("spur.n_valid", n_iv + n_dv, 0);
    chk("spur.n_done", n_idone + n_ddone, 0);

    // Both misses held continuously: owners alternate starting with D.
    clear_trackers();
    hold = 1'b1;
    icache_addr = 16'h5550; dcache_addr = 16'h6660;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    budget = 0;
    while (order_q.size() < 4 && budget < 200) begin cycle(); budget++; end
    chk("alt.in_budget", budget < 200, 1);
    for (int j = 0; j < order_q.size() && j < 4; j++) chk("alt.owner_is_d", order_q[j], (j % 2 == 0) ? 1 : 0);
    hold = 1'b0;
    run_until_idle("alt_drain");

    // Asynchronous reset in the middle of a D fill, then a clean restart.
    clear_trackers();
    dcache_addr = 16'h4A52; dcache_miss = 1'b1;
    budget = 0;
    while (!(srv == S_D && recv == 3) && budget < 40) begin cycle(); budget++; end
    chk("rst.reached_word3", budget < 40, 1);
    rst_n = 1'b0; dcache_miss = 1'b0; spur = 1'b0; mem_data_valid = 1'b0;
    #1;
    check_all_zero("rst_mid_fill");
    reset_model();
    cycle(); cycle();
    rst_n = 1'b1;
    clear_trackers();
    dcache_miss = 1'b1;
    run_until_idle("rst_refill");
    chk("rst.restart_base", rd_start_addr, 16'h4A50);
    chk("rst.n_dvalid", n_dv, 8);
    chk("rst.n_ddone", n_ddone, 1);

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    for (int j = 0; j < 1500; j++) cycle();
    rand_mode = 1'b0;
    spur = 1'b0;
    run_until_idle("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
